arb_rr_ctrl: RTL and testbench

- Round-robin grant controller that shares one downstream resource among NUM_AGENTS requesters using a req/ack handshake.
- Produces a registered one-hot ack: the agent that holds ack owns the resource for as long as it keeps req high.
- Sits between the agent request lines and the shared datapath mux.
- Its req/ack ports are the ones monitored by the arbiter cover-point module.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/arb_rr_pick.sv | 49 ++++
 rtl/arb_rr_ctrl.sv | 154 +++++++++++++++
 tb/tb_arb_rr_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkg
// Purpose : Shared types and constants for the round-robin grant controller.
//           - arb_state_t : controller state encoding (IDLE / OWN)
//           - HOLD_W      : width of the optional hold counter
//           - idx_w()     : index width for N agents, never below 1 bit
// Revision: 1.0 - initial release
// ============================================================================
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int HOLD_W = 8;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : arb_rr_pick
// Purpose : Combinational rotate-priority encoder. Scans req starting at ptr,
//           wrapping modulo NUM_AGENTS, and returns the first set bit that is
//           not the excluded index.
// Ports   : req      [NUM_AGENTS-1:0] request levels
//           ptr      [IDX_W-1:0]      scan start index
//           excl_vld                  exclusion enable
//           excl_idx [IDX_W-1:0]      index never selected when excl_vld
//           found                     a winner exists
//           idx      [IDX_W-1:0]      winner index (0 when !found)
// Revision: 1.0 - initial release
// ============================================================================
module arb_rr_pick #(
    parameter int NUM_AGENTS = 2,
    parameter int IDX_W      = 1
) (
    input  logic [NUM_AGENTS-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    input  logic                  excl_vld,
    input  logic [IDX_W-1:0]      excl_idx,
    output logic                  found,
    output logic [IDX_W-1:0]      idx
);

    int               w_cand;
    logic [IDX_W-1:0] w_cidx;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = 0;
        w_cidx = '0;
        for (int k = 0; k < NUM_AGENTS; k++) begin
            w_cand = int'(ptr) + k;
            if (w_cand >= NUM_AGENTS) begin
                w_cand = w_cand - NUM_AGENTS;
            end
            w_cidx = IDX_W'(w_cand);
            if (!found && req[w_cidx] && !(excl_vld && (excl_idx == w_cidx))) begin
                found = 1'b1;
                idx   = w_cidx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : arb_rr_ctrl
// Purpose : Round-robin req/ack grant controller for one shared resource.
//           The owner keeps a registered one-hot ack while its req stays
//           high; on release the next requester is handed the grant in the
//           same edge (no idle bubble).
// Ports   : clk                     rising-edge clock
//           rst                     asynchronous reset, active low
//           req    [NUM_AGENTS-1:0] per-agent request level
//           ack    [NUM_AGENTS-1:0] registered one-hot grant
//           ack_id [IDX_W-1:0]      binary owner index (0 when idle)
//           busy                    |ack
// Options : ARB_HOLD_LIMIT_EN - forces release after MAX_HOLD owned cycles
//           when another agent is waiting.
// Revision: 1.0 - initial release
// ============================================================================
module arb_rr_ctrl
    import arb_pkg::*;
#(
    parameter int NUM_AGENTS = 2,
    parameter int MAX_HOLD   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_AGENTS-1:0]            req,
    output logic [NUM_AGENTS-1:0]            ack,
    output logic [idx_w(NUM_AGENTS)-1:0]     ack_id,
    output logic                             busy
);

    localparam int                  c_IDX_W = idx_w(NUM_AGENTS);
    localparam logic [NUM_AGENTS-1:0] c_ONE = NUM_AGENTS'(1);

    if (NUM_AGENTS < 2 || NUM_AGENTS > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("arb_rr_ctrl: parameter out of range");
    end

    arb_state_t              r_state, w_state_nxt;
    logic [NUM_AGENTS-1:0]   r_ack, w_ack_nxt;
    logic [c_IDX_W-1:0]      r_ack_id, w_id_nxt;
    logic [c_IDX_W-1:0]      r_ptr, w_ptr_nxt;
    logic [c_IDX_W-1:0]      w_optr;
    logic [c_IDX_W-1:0]      w_pick_ptr;
    logic                    w_found;
    logic [c_IDX_W-1:0]      w_pick_idx;
    logic                    w_own;
    logic                    w_force;
    logic                    w_release;

    assign w_own     = (r_state == OWN);
    // Pointer one past the current owner, wrapping at NUM_AGENTS.
    assign w_optr    = (r_ack_id == c_IDX_W'(NUM_AGENTS - 1)) ? '0 : r_ack_id + c_IDX_W'(1);
    assign w_release = w_own && (!req[r_ack_id] || w_force);
    // While owning, the only pick that matters is the release re-pick, which
    // scans from one past the owner; in IDLE it scans from the stored pointer.
    assign w_pick_ptr = w_own ? w_optr : r_ptr;

    arb_rr_pick #(
        .NUM_AGENTS (NUM_AGENTS),
        .IDX_W      (c_IDX_W)
    ) u_pick (
        .req      (req),
        .ptr      (w_pick_ptr),
        .excl_vld (w_own),
        .excl_idx (r_ack_id),
        .found    (w_found),
        .idx      (w_pick_idx)
    );

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [HOLD_W-1:0] c_HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] c_HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic              w_others;

    assign w_others = |(req & ~r_ack);
    // >= rather than == so an owner that saturated while alone is still
    // preempted once another agent starts waiting.
    assign w_force  = w_own && (r_hold >= c_HOLD_LIM) && w_others;

    always_comb begin
        w_hold_nxt = '0;
        if (w_own && !w_release) begin
            w_hold_nxt = (r_hold == c_HOLD_MAX) ? r_hold : r_hold + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_id_nxt    = r_ack_id;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = OWN;
                    w_ack_nxt   = c_ONE << w_pick_idx;
                    w_id_nxt    = w_pick_idx;
                end
            end
            OWN: begin
                if (w_release) begin
                    w_ptr_nxt = w_optr;
                    if (w_found) begin
                        w_ack_nxt = c_ONE << w_pick_idx;
                        w_id_nxt  = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_ack_nxt   = '0;
                        w_id_nxt    = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ack_nxt   = '0;
                w_id_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_ack    <= '0;
            r_ack_id <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ack    <= w_ack_nxt;
            r_ack_id <= w_id_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    assign ack    = r_ack;
    assign ack_id = r_ack_id;
    assign busy   = |r_ack;

endmodule
`default_nettype wire

// File: tb/tb_arb_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_arb_rr_ctrl
// Purpose : Self-checking bench for arb_rr_ctrl. A 2-agent instance runs a
//           directed vector table plus reset and hold sequences; a 4-agent
//           instance runs the round-robin fairness sequence.
// Revision: 1.0 - initial release
// ============================================================================
module tb_arb_rr_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] req2;
    logic [1:0] ack2;
    logic       id2;
    logic       busy2;
    logic [3:0] req4;
    logic [3:0] ack4;
    logic [1:0] id4;
    logic       busy4;

    int n_pass;
    int n_total;

    arb_rr_ctrl #(.NUM_AGENTS(2), .MAX_HOLD(4)) u_dut2 (
        .clk    (clk),
        .rst    (rst),
        .req    (req2),
        .ack    (ack2),
        .ack_id (id2),
        .busy   (busy2)
    );

    arb_rr_ctrl #(.NUM_AGENTS(4), .MAX_HOLD(16)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .req    (req4),
        .ack    (ack4),
        .ack_id (id4),
        .busy   (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] req;
        logic [1:0] ack;
        logic       id;
        logic       busy;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check2(input string name, input logic [1:0] exp_ack, input logic exp_id);
        check({name, "_ack"}, 32'(ack2), 32'(exp_ack));
        check({name, "_id"}, 32'(id2), 32'(exp_id));
        check({name, "_busy"}, 32'(busy2), 32'(|exp_ack));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [1:0] exp2;
        logic [3:0] exp4;

        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        req2    = 2'b00;
        req4    = 4'b0000;

        // Reset state
        tick();
        tick();
        check2("reset", 2'b00, 1'b0);
        check("reset4_ack", 32'(ack4), 32'h0);
        rst = 1'b1;

        // Directed vectors: req applied, ack expected after the next edge.
        vecs[0]  = '{req: 2'b00, ack: 2'b00, id: 1'b0, busy: 1'b0};
        vecs[1]  = '{req: 2'b01, ack: 2'b01, id: 1'b0, busy: 1'b1};
        vecs[2]  = '{req: 2'b01, ack: 2'b01, id: 1'b0, busy: 1'b1};
        vecs[3]  = '{req: 2'b00, ack: 2'b00, id: 1'b0, busy: 1'b0};
        vecs[4]  = '{req: 2'b11, ack: 2'b10, id: 1'b1, busy: 1'b1};
        vecs[5]  = '{req: 2'b01, ack: 2'b01, id: 1'b0, busy: 1'b1};
        vecs[6]  = '{req: 2'b11, ack: 2'b01, id: 1'b0, busy: 1'b1};
        vecs[7]  = '{req: 2'b10, ack: 2'b10, id: 1'b1, busy: 1'b1};
        vecs[8]  = '{req: 2'b11, ack: 2'b10, id: 1'b1, busy: 1'b1};
        vecs[9]  = '{req: 2'b01, ack: 2'b01, id: 1'b0, busy: 1'b1};
        vecs[10] = '{req: 2'b00, ack: 2'b00, id: 1'b0, busy: 1'b0};
        vecs[11] = '{req: 2'b10, ack: 2'b10, id: 1'b1, busy: 1'b1};
        vecs[12] = '{req: 2'b00, ack: 2'b00, id: 1'b0, busy: 1'b0};

        for (int i = 0; i < 13; i++) begin
            req2 = vecs[i].req;
            tick();
            check($sformatf("vec%0d_ack", i), 32'(ack2), 32'(vecs[i].ack));
            check($sformatf("vec%0d_id", i), 32'(id2), 32'(vecs[i].id));
            check($sformatf("vec%0d_busy", i), 32'(busy2), 32'(vecs[i].busy));
        end

        // Asynchronous reset mid-grant; pointer must restart at 0.
        req2 = 2'b11;
        tick();
        check2("pre_rst_grant0", 2'b01, 1'b0);
        req2 = 2'b10;
        tick();
        check2("pre_rst_grant1", 2'b10, 1'b1);
        #2 rst = 1'b0;
        #1;
        check2("async_rst", 2'b00, 1'b0);
        req2 = 2'b11;
        tick();
        check2("rst_held", 2'b00, 1'b0);
        rst = 1'b1;
        tick();
        check2("post_rst_ptr0", 2'b01, 1'b0);
        req2 = 2'b00;
        tick();

        // 4-agent fairness: each owner holds 3 cycles then drops for one.
        do_reset();
        req4 = 4'hF;
        for (int g = 0; g < 5; g++) begin
            exp4 = 4'b0001 << (g % 4);
            tick();
            req4 = 4'hF;
            check($sformatf("rr4_grant%0d", g), 32'(ack4), 32'(exp4));
            check($sformatf("rr4_id%0d", g), 32'(id4), g % 4);
            for (int c = 0; c < 2; c++) begin
                tick();
                check("rr4_hold", 32'(ack4), 32'(exp4));
                check("rr4_onehot", 32'($onehot(ack4)), 32'd1);
            end
            req4 = 4'hF & ~exp4;
        end
        req4 = 4'h0;
        tick();
        tick();
        check("rr4_idle", 32'(busy4), 32'd0);

`ifdef ARB_HOLD_LIMIT_EN
        // Forced release every MAX_HOLD=4 owned cycles.
        do_reset();
        req2 = 2'b11;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp2 = (((k / 4) % 2) == 1) ? 2'b10 : 2'b01;
            check($sformatf("hold_k%0d", k), 32'(ack2), 32'(exp2));
        end
        req2 = 2'b01;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("hold_alone", 32'(ack2), 32'h1);
        end
`else
        // Owner keeps the grant indefinitely while req stays high.
        do_reset();
        req2 = 2'b11;
        for (int k = 0; k < 50; k++) begin
            tick();
            check("nohold_own0", 32'(ack2), 32'h1);
        end
        req2 = 2'b10;
        tick();
        check2("nohold_handover", 2'b10, 1'b1);
`endif
        req2 = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
